// File: rtl/l1_cache_ctrl.sv
// l1_cache_ctrl: set-associative L1 controller holding tag, MESI and true-LRU
// arrays; sequential lookup/update engine with a one-set-per-cycle clear sweep.
module l1_cache_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 64,
    parameter int SETS       = 16384,
    parameter int WAYS       = 8,
    parameter int CNT_W      = 32,
    parameter int OFF_W      = $clog2(LINE_BYTES),
    parameter int IDX_W      = $clog2(SETS),
    parameter int WAY_W      = $clog2(WAYS),
    parameter int TAG_W      = ADDR_W - OFF_W - IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_cmd,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              shared_i,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [WAY_W-1:0]  resp_way,
    output logic [1:0]        resp_mesi,
    output logic [1:0]        resp_bus_op,
    output logic              resp_wb,
    output logic [TAG_W-1:0]  resp_wb_tag,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOOKUP, S_UPDATE} state_t;
    typedef enum logic [1:0] {MESI_I = 2'b00, MESI_S = 2'b01, MESI_E = 2'b10, MESI_M = 2'b11} mesi_t;
    typedef enum logic [1:0] {BUS_NONE, BUS_READ, BUS_RFO, BUS_INV} bus_t;

    localparam logic [3:0] CMD_READ   = 4'd0;
    localparam logic [3:0] CMD_WRITE  = 4'd1;
    localparam logic [3:0] CMD_IFETCH = 4'd2;
    localparam logic [3:0] CMD_L2_INV = 4'd3;
    localparam logic [3:0] CMD_SNOOP  = 4'd4;
    localparam logic [3:0] CMD_CLEAR  = 4'd8;

    state_t state, next_state;

    logic [TAG_W-1:0] tag_arr  [SETS][WAYS];
    mesi_t            mesi_arr [SETS][WAYS];
    logic [WAY_W-1:0] lru_arr  [SETS][WAYS];

    logic [IDX_W-1:0]  clr_idx;
    logic              clr_resp;
    logic [3:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic              shr_q;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit, inv_found;
    logic [WAY_W-1:0] lk_hit_way, inv_way, lru_way, vic_way;
    mesi_t            hit_mesi, vic_mesi;
    logic [TAG_W-1:0] vic_tag;

    logic             d_hit, d_wb, d_wen, d_tag_wr, d_touch, d_cnt_hit, d_cnt_miss;
    logic [WAY_W-1:0] d_way;
    mesi_t            d_mesi;
    bus_t             d_bus;
    logic [TAG_W-1:0] d_wb_tag;

    logic             upd_wen, upd_tag_wr, upd_touch;
    logic [WAY_W-1:0] upd_way;
    mesi_t            upd_mesi;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_CLEAR;
        else     state <= next_state;
    end

    // Next-state and ready decode.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        case (state)
            S_CLEAR:  if (clr_idx == IDX_W'(SETS - 1)) next_state = S_IDLE;
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = (req_cmd == CMD_CLEAR) ? S_CLEAR : S_LOOKUP;
            end
            S_LOOKUP: next_state = S_UPDATE;
            S_UPDATE: next_state = S_IDLE;
            default:  next_state = S_CLEAR;
        endcase
    end

    // Tag compare, first-invalid and LRU-victim search over the looked-up set.
    always_comb begin
        lk_idx     = addr_q[OFF_W +: IDX_W];
        lk_tag     = addr_q[ADDR_W-1 -: TAG_W];
        lk_hit     = 1'b0;
        lk_hit_way = '0;
        inv_found  = 1'b0;
        inv_way    = '0;
        lru_way    = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (mesi_arr[lk_idx][w] != MESI_I && tag_arr[lk_idx][w] == lk_tag) begin
                lk_hit     = 1'b1;
                lk_hit_way = WAY_W'(w);
            end
            if (mesi_arr[lk_idx][w] == MESI_I && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
            if (lru_arr[lk_idx][w] == '0) lru_way = WAY_W'(w);
        end
        vic_way  = inv_found ? inv_way : lru_way;
        hit_mesi = mesi_arr[lk_idx][lk_hit_way];
        vic_mesi = mesi_arr[lk_idx][vic_way];
        vic_tag  = tag_arr[lk_idx][vic_way];
    end

    // Command decision: response fields, array write intent and counter bumps.
    always_comb begin
        d_hit      = 1'b0;
        d_way      = '0;
        d_mesi     = MESI_I;
        d_bus      = BUS_NONE;
        d_wb       = 1'b0;
        d_wb_tag   = '0;
        d_wen      = 1'b0;
        d_tag_wr   = 1'b0;
        d_touch    = 1'b0;
        d_cnt_hit  = 1'b0;
        d_cnt_miss = 1'b0;
        case (cmd_q)
            CMD_READ, CMD_WRITE, CMD_IFETCH: begin
                d_touch = 1'b1;
                d_wen   = 1'b1;
                if (lk_hit) begin
                    d_hit     = 1'b1;
                    d_way     = lk_hit_way;
                    d_cnt_hit = 1'b1;
                    if (cmd_q == CMD_WRITE) begin
                        d_mesi = MESI_M;
                        d_bus  = (hit_mesi == MESI_S) ? BUS_INV : BUS_NONE;
                    end else begin
                        d_mesi = hit_mesi;
                    end
                end else begin
                    d_way      = vic_way;
                    d_cnt_miss = 1'b1;
                    d_tag_wr   = 1'b1;
                    d_wb       = (vic_mesi == MESI_M);
                    d_wb_tag   = (vic_mesi == MESI_M) ? vic_tag : '0;
                    if (cmd_q == CMD_WRITE) begin
                        d_mesi = MESI_M;
                        d_bus  = BUS_RFO;
                    end else begin
                        d_mesi = shr_q ? MESI_S : MESI_E;
                        d_bus  = BUS_READ;
                    end
                end
            end
            CMD_L2_INV: if (lk_hit) begin
                d_hit  = 1'b1;
                d_way  = lk_hit_way;
                d_mesi = MESI_I;
                d_wen  = 1'b1;
            end
            CMD_SNOOP: if (lk_hit) begin
                d_hit    = 1'b1;
                d_way    = lk_hit_way;
                d_mesi   = MESI_S;
                d_wen    = 1'b1;
                d_wb     = (hit_mesi == MESI_M);
                d_wb_tag = (hit_mesi == MESI_M) ? lk_tag : '0;
            end
            default: ;
        endcase
    end

    // Request capture, response register, sweep index and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_idx     <= '0;
            clr_resp    <= 1'b0;
            cmd_q       <= '0;
            addr_q      <= '0;
            shr_q       <= 1'b0;
            resp_valid  <= 1'b0;
            resp_hit    <= 1'b0;
            resp_way    <= '0;
            resp_mesi   <= '0;
            resp_bus_op <= '0;
            resp_wb     <= 1'b0;
            resp_wb_tag <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
            upd_wen     <= 1'b0;
            upd_tag_wr  <= 1'b0;
            upd_touch   <= 1'b0;
            upd_way     <= '0;
            upd_mesi    <= MESI_I;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_CLEAR: begin
                    clr_idx <= clr_idx + IDX_W'(1);
                    if (clr_idx == IDX_W'(SETS - 1)) begin
                        // Only a commanded clear reports completion; a reset sweep is silent.
                        resp_valid  <= clr_resp;
                        resp_hit    <= 1'b0;
                        resp_way    <= '0;
                        resp_mesi   <= '0;
                        resp_bus_op <= '0;
                        resp_wb     <= 1'b0;
                        resp_wb_tag <= '0;
                        clr_resp    <= 1'b0;
                        clr_idx     <= '0;
                    end
                end
                S_IDLE: if (req_valid) begin
                    cmd_q  <= req_cmd;
                    addr_q <= req_addr;
                    shr_q  <= shared_i;
                    if (req_cmd == CMD_CLEAR) begin
                        clr_resp <= 1'b1;
                        clr_idx  <= '0;
                        hit_cnt  <= '0;
                        miss_cnt <= '0;
                    end
                end
                S_LOOKUP: begin
                    resp_valid  <= 1'b1;
                    resp_hit    <= d_hit;
                    resp_way    <= d_way;
                    resp_mesi   <= d_mesi;
                    resp_bus_op <= d_bus;
                    resp_wb     <= d_wb;
                    resp_wb_tag <= d_wb_tag;
                    upd_wen     <= d_wen;
                    upd_tag_wr  <= d_tag_wr;
                    upd_touch   <= d_touch;
                    upd_way     <= d_way;
                    upd_mesi    <= d_mesi;
                    if (d_cnt_hit && hit_cnt != '1)   hit_cnt  <= hit_cnt + CNT_W'(1);
                    if (d_cnt_miss && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Array writes: sweep one set per cycle, or commit the registered update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_CLEAR) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    mesi_arr[clr_idx][w] <= MESI_I;
                    lru_arr[clr_idx][w]  <= WAY_W'(w);
                end
            end else if (state == S_UPDATE) begin
                if (upd_wen)    mesi_arr[lk_idx][upd_way] <= upd_mesi;
                if (upd_tag_wr) tag_arr[lk_idx][upd_way]  <= lk_tag;
                if (upd_touch) begin
                    for (int unsigned w = 0; w < WAYS; w++) begin
                        if (lru_arr[lk_idx][w] > lru_arr[lk_idx][upd_way])
                            lru_arr[lk_idx][w] <= lru_arr[lk_idx][w] - WAY_W'(1);
                    end
                    lru_arr[lk_idx][upd_way] <= WAY_W'(WAYS - 1);
                end
            end
        end
    end
endmodule

// File: tb/tb_l1_cache_ctrl.sv
// tb_l1_cache_ctrl: directed and randomized checks of l1_cache_ctrl (4 sets,
// 2 ways) against a timestamp-LRU behavioural cache model.
module tb_l1_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_cmd = '0;
    logic [31:0] req_addr = '0;
    logic        shared_i = 1'b0;
    logic        resp_valid, resp_hit, resp_wb;
    logic [0:0]  resp_way;
    logic [1:0]  resp_mesi, resp_bus_op;
    logic [23:0] resp_wb_tag;
    logic [31:0] hit_cnt, miss_cnt;

    int total = 0;
    int bad   = 0;

    l1_cache_ctrl #(.ADDR_W(32), .LINE_BYTES(64), .SETS(4), .WAYS(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_addr(req_addr), .shared_i(shared_i),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
        .resp_mesi(resp_mesi), .resp_bus_op(resp_bus_op), .resp_wb(resp_wb),
        .resp_wb_tag(resp_wb_tag), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: per-line tag/state plus a last-use timestamp per way.
    typedef struct {
        int hit; int way; int mesi; int bus; int wb; int wbtag;
    } resp_t;

    int m_tag [4][2];
    int m_mesi[4][2];   // 0 I, 1 S, 2 E, 3 M
    int m_use [4][2];
    int m_tick;
    int m_hits, m_miss;

    function automatic void model_clear();
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 2; w++) begin
                m_tag[s][w]  = 0;
                m_mesi[s][w] = 0;
                m_use[s][w]  = w;
            end
        m_tick = 10;
    endfunction

    function automatic void model_touch(input int s, input int w);
        m_tick++;
        m_use[s][w] = m_tick;
    endfunction

    function automatic resp_t model_apply(input int cmd, input logic [31:0] a, input bit shr);
        resp_t r;
        int s, tg, hw, v;
        r = '{hit: 0, way: 0, mesi: 0, bus: 0, wb: 0, wbtag: 0};
        s  = int'((a >> 6) & 32'd3);
        tg = int'(a >> 8);
        if (cmd == 8) begin
            model_clear();
            m_hits = 0;
            m_miss = 0;
            return r;
        end
        hw = -1;
        for (int w = 0; w < 2; w++)
            if (m_mesi[s][w] != 0 && m_tag[s][w] == tg) hw = w;
        if (cmd == 0 || cmd == 1 || cmd == 2) begin
            if (hw >= 0) begin
                r.hit = 1;
                r.way = hw;
                if (cmd == 1) begin
                    r.bus = (m_mesi[s][hw] == 1) ? 3 : 0;
                    m_mesi[s][hw] = 3;
                end
                r.mesi = m_mesi[s][hw];
                model_touch(s, hw);
                m_hits++;
            end else begin
                v = -1;
                for (int w = 0; w < 2; w++)
                    if (m_mesi[s][w] == 0 && v < 0) v = w;
                if (v < 0) v = (m_use[s][0] < m_use[s][1]) ? 0 : 1;
                if (m_mesi[s][v] == 3) begin
                    r.wb    = 1;
                    r.wbtag = m_tag[s][v];
                end
                r.way  = v;
                r.mesi = (cmd == 1) ? 3 : (shr ? 1 : 2);
                r.bus  = (cmd == 1) ? 2 : 1;
                m_tag[s][v]  = tg;
                m_mesi[s][v] = r.mesi;
                model_touch(s, v);
                m_miss++;
            end
        end else if (cmd == 3 && hw >= 0) begin
            r.hit = 1;
            r.way = hw;
            m_mesi[s][hw] = 0;
        end else if (cmd == 4 && hw >= 0) begin
            r.hit = 1;
            r.way = hw;
            if (m_mesi[s][hw] == 3) begin
                r.wb    = 1;
                r.wbtag = tg;
            end
            m_mesi[s][hw] = 1;
            r.mesi = 1;
        end
        return r;
    endfunction

    // Pulse reset (optionally again mid-sweep) and check the silent 4-cycle sweep.
    task automatic reset_and_check(input bit mid);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        m_hits = 0;
        m_miss = 0;
        if (mid) begin
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            check("sweep_ready", req_ready, 0);
            check("sweep_no_resp", resp_valid, 0);
            @(negedge clk);
        end
        check("ready_after_sweep", req_ready, 1);
        check("no_resp_after_sweep", resp_valid, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        check("rst_resp_fields", {resp_hit, resp_way, resp_mesi, resp_bus_op, resp_wb, resp_wb_tag}, 0);
    endtask

    task automatic send(input logic [3:0] c, input logic [31:0] a, input bit shr);
        resp_t e;
        int n, exp_lat;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", req_ready, 1);
        req_valid = 1'b1;
        req_cmd   = c;
        req_addr  = a;
        shared_i  = shr;
        @(posedge clk);
        e = model_apply(int'(c), a, shr);
        @(negedge clk);
        req_valid = 1'b0;
        exp_lat = (c == 4'd8) ? 5 : 2;
        n = 1;
        while (!resp_valid && n < 12) begin
            check("busy_ready", req_ready, 0);
            @(negedge clk);
            n++;
        end
        check("resp_latency", n, exp_lat);
        check("resp_valid", resp_valid, 1);
        check("ready_at_resp", req_ready, (c == 4'd8) ? 1 : 0);
        check("resp_hit", resp_hit, e.hit);
        check("resp_way", resp_way, e.way);
        check("resp_mesi", resp_mesi, e.mesi);
        check("resp_bus_op", resp_bus_op, e.bus);
        check("resp_wb", resp_wb, e.wb);
        check("resp_wb_tag", resp_wb_tag, e.wbtag);
        check("hit_cnt", hit_cnt, m_hits);
        check("miss_cnt", miss_cnt, m_miss);
        @(negedge clk);
        check("resp_pulse", resp_valid, 0);
    endtask

    initial begin
        int r;
        logic [3:0]  c;
        logic [31:0] a;
        reset_and_check(1'b0);
        reset_and_check(1'b1);

        // Read allocate then hit.
        send(4'd0, 32'h100, 1'b0);
        send(4'd0, 32'h100, 1'b0);
        // Write hit, write allocate, dirty eviction.
        send(4'd1, 32'h100, 1'b0);
        send(4'd1, 32'h200, 1'b0);
        send(4'd0, 32'h300, 1'b0);
        // Snoop of a dirty line, L2 invalidate, invalid-way preference, S->M upgrade.
        send(4'd4, 32'h200, 1'b0);
        send(4'd3, 32'h200, 1'b0);
        send(4'd0, 32'h100, 1'b1);
        send(4'd1, 32'h100, 1'b0);
        // Clear command then re-allocate.
        send(4'd8, 32'h0, 1'b0);
        send(4'd0, 32'h300, 1'b0);
        // Unsupported commands leave state alone.
        send(4'd9, 32'h300, 1'b0);
        send(4'd5, 32'h300, 1'b0);
        send(4'd0, 32'h300, 1'b0);
        send(4'd3, 32'h700, 1'b0);
        send(4'd4, 32'h700, 1'b0);

        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if      (r < 30) c = 4'd0;
            else if (r < 55) c = 4'd1;
            else if (r < 68) c = 4'd2;
            else if (r < 80) c = 4'd3;
            else if (r < 91) c = 4'd4;
            else if (r < 93) c = 4'd8;
            else if (r < 96) c = 4'($urandom_range(5, 7));
            else             c = 4'($urandom_range(9, 15));
            a = ($urandom_range(1, 5) << 8) | ($urandom_range(0, 3) << 6) | $urandom_range(0, 63);
            send(c, a, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) @(negedge clk);
        end

        reset_and_check(1'b0);
        send(4'd1, 32'h140, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/l1_cache_ctrl.md
Name: l1_cache_ctrl

Overview:
Parametrised set-associative L1 cache controller that holds the tag, MESI and LRU arrays for one split-cache half. It generalises the fixed 4-way/8-way combinational way-select into a sequential engine with configurable sets and ways, true-LRU tracking, MESI transitions and a clear sweep. It sits between the trace-command driver and the L2/bus model, and one instance is used for the instruction cache and one for the data cache.

Parameters:
ADDR_W, 32, address width
LINE_BYTES, 64, line size; OFF_W = log2(LINE_BYTES)
SETS, 16384, number of sets; IDX_W = log2(SETS)
WAYS, 8, associativity, power of 2 and ≥2; WAY_W = log2(WAYS)
CNT_W, 32, width of the statistics counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  command valid
req_ready  out  1  controller can accept a command
req_cmd  in  4  trace command: 0 read, 1 write, 2 ifetch, 3 L2 invalidate, 4 snoop read, 8 clear; all other values are no-ops
req_addr  in  ADDR_W  byte address; tag=[ADDR_W-1:OFF_W+IDX_W], idx=[OFF_W+IDX_W-1:OFF_W]
shared_i  in  1  another cache holds the line; sampled with the request
resp_valid  out  1  one-cycle response strobe
resp_hit  out  1  tag matched a non-Invalid way
resp_way  out  WAY_W  way hit or allocated
resp_mesi  out  2  new state of resp_way: I=00, S=01, E=10, M=11
resp_bus_op  out  2  0 none, 1 READ, 2 RFO, 3 INVALIDATE
resp_wb  out  1  dirty line written back
resp_wb_tag  out  TAG_W  tag of the written-back line
hit_cnt, miss_cnt  out  CNT_W  saturating statistics; cmds 0/1/2 only

Behaviour:
- States: CLEAR, IDLE, LOOKUP, UPDATE. req_ready=1 only in IDLE.
- rst (any state): go to CLEAR with idx=0; zero the counters; drive all resp_* to 0. After the sweep the controller goes to IDLE without a resp_valid. Asserting rst mid-sweep restarts the sweep at 0.
- CLEAR sweep: one set per cycle, SETS cycles. Each set gets all ways MESI=I and lru[w]=w.
- Command timing:
  - Accept at edge k (IDLE & req_valid) → LOOKUP. Registers hold cmd/addr/shared_i and read set idx.
  - Edge k+1 → UPDATE. Hit, hit way and victim are registered; resp_valid=1 during this cycle.
  - Edge k+2 → arrays written, return to IDLE. Next accept is at edge k+3 at the earliest.
  - There is no read-after-write hazard.
- Hit test: tag equal AND MESI≠I. At most one way may match.
- Victim: lowest-index Invalid way; otherwise the way with lru==0. If the victim is M: resp_wb=1 and resp_wb_tag=victim tag.
- LRU is a permutation 0..WAYS-1, with WAYS-1 = MRU. On touch of way w, every way with lru>lru[w] decrements, then lru[w]=WAYS-1. Touch happens on cmds 0/1/2 only.
- MESI transitions:
  - read/ifetch miss → S if shared_i else E, bus READ.
  - read/ifetch hit → state unchanged, bus none.
  - write miss → M, bus RFO.
  - write hit: S→M with bus INVALIDATE; E/M→M with bus none.
  - cmd 3 hit → I; miss → no change. LRU untouched.
  - cmd 4 hit: M→S with resp_wb=1 (wb_tag = own tag); E→S; S→S. Miss → no change.
- cmd 8: accepted → CLEAR sweep → one resp_valid (hit=0) → IDLE. Counters are zeroed at the start of the sweep.
- Unsupported cmds: resp_valid with hit=0, bus none, wb=0; no array or counter change.
- On a miss, resp_way = victim. On cmd 3/4/no-op miss, resp_way=0 and resp_mesi=I.
- Counters saturate at all-ones and never wrap.

Test Plan:
Overrides for all scenarios: SETS=4, WAYS=2. Addresses: 0x100 = set0/tag1, 0x200 = set0/tag2, 0x300 = set0/tag3.
1. Pulse rst 1 cycle → req_ready=0 for 4 cycles then 1; no resp_valid; hit_cnt=miss_cnt=0. rst at sweep cycle 2 → ready stays low 4 more cycles.
2. Read 0x100 with shared_i=0 → 2 cycles after accept: hit=0, way=0, E, READ. Repeat read → hit=1, way=0, E, none. Counters hit=1, miss=1.
3. Write 0x100 → hit, M, none. Write 0x200 → miss, way=1, M, RFO. Read 0x300 → way=0, wb=1, wb_tag=1, E.
4. Cmd 4 on 0x200 → S, wb=1, wb_tag=2. Cmd 3 on 0x200 → I. Read 0x100 with shared_i=1 → miss, way=1 (invalid preferred), S. Write 0x100 → M, INVALIDATE.
5. Cmd 8 → ready low 4 cycles, one resp_valid. Then read 0x300 → miss, way=0; counters hit=0, miss=1.
6. Cmd 9 and cmd 5 → resp_valid with hit=0, bus none; counters and array contents unchanged.
